// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encodings and default width.
package serial_add_ctrl_pkg;

   localparam int unsigned DEF_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : serial_add_ctrl_pkg

// File: rtl/serial_add_ctrl_fa.sv
// Single-bit full-adder cell shared by the serial adder controller.
module fa (
   input  logic ai,
   input  logic bi,
   input  logic ci,
   output logic so,
   output logic co
);

   always_comb begin
      so = ai ^ bi ^ ci;
      co = (ai & bi) | (ai & ci) | (bi & ci);
   end

endmodule : fa

// File: rtl/serial_add_ctrl.sv
// Bit-serial W-bit adder sequencing one full-adder cell, LSB first, one bit per cycle.
// Optional subtract mode (sub port, inverted B, carry seeded with 1) is enabled by SERIAL_ADD_SUB_EN.
module serial_add_ctrl
   import serial_add_ctrl_pkg::*;
#(
   parameter int unsigned W = DEF_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
   input  logic         sub,
`endif
   output logic         busy,
   output logic         done,
   output logic [W-1:0] sum,
   output logic         cout
);

   localparam int unsigned CNT_W = $clog2(W + 1);

   if (W < 2 || W > 32) begin : g_bad_width
      $error("serial_add_ctrl: W must be in 2..32");
   end

   state_t             state_q;
   state_t             state_d;
   logic [W-1:0]       a_sr;
   logic [W-1:0]       b_sr;
   logic [W-1:0]       sum_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               carry_q;
   logic               cout_q;
   logic               sub_q;
   logic               sub_in;
   logic               accept;
   logic               step;
   logic               last;
   logic               fa_bi;
   logic               fa_so;
   logic               fa_co;

`ifdef SERIAL_ADD_SUB_EN
   always_comb sub_in = sub;
`else
   always_comb sub_in = 1'b0;
`endif

   always_comb last = (cnt_q == CNT_W'(W - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // accept: load operands this edge; step: consume one bit slice this edge
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      step    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            step = 1'b1;
            if (last) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb fa_bi = b_sr[0] ^ sub_q;

   fa u_fa (
      .ai (a_sr[0]),
      .bi (fa_bi),
      .ci (carry_q),
      .so (fa_so),
      .co (fa_co)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr    <= '0;
         b_sr    <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         sub_q   <= 1'b0;
      end else if (accept) begin
         a_sr    <= a;
         b_sr    <= b;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= sub_in;
         cout_q  <= 1'b0;
         sub_q   <= sub_in;
      end else if (step) begin
         a_sr    <= a_sr >> 1;
         b_sr    <= b_sr >> 1;
         sum_q   <= {fa_so, sum_q[W-1:1]};
         carry_q <= fa_co;
         cnt_q   <= cnt_q + 1'b1;
         if (last) cout_q <= fa_co;
      end
   end

   always_comb begin
      busy = (state_q == ST_RUN);
      done = (state_q == ST_DONE);
      sum  = sum_q;
      cout = cout_q;
   end

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at W=8 (subtract cases under SERIAL_ADD_SUB_EN).
module tb_serial_add_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       sub;
   logic       busy;
   logic       done;
   logic [7:0] sum;
   logic       cout;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   serial_add_ctrl #(.W(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
`ifdef SERIAL_ADD_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // drive operands with start for one edge; returns at the first RUN cycle
   task automatic do_start(input logic [7:0] av, input logic [7:0] bv, input logic sv);
      @(negedge clk);
      a     = av;
      b     = bv;
      sub   = sv;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // counts busy cycles from now until done, then checks result and handshake
   task automatic wait_done(input string tag, input logic [7:0] es, input logic ec, input int exp_busy);
      int  nb      = 0;
      bit  seen    = 1'b0;
      bit  overlap = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (busy && done) overlap = 1'b1;
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) nb++;
         @(negedge clk);
      end
      chk({tag, "_done_seen"}, 32'(seen), 32'd1);
      chk({tag, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
      chk({tag, "_busy_done_overlap"}, 32'(overlap), 32'd0);
      chk({tag, "_sum"}, 32'(sum), 32'(es));
      chk({tag, "_cout"}, 32'(cout), 32'(ec));
   endtask

   // after done: pulse is one cycle wide and result stays held
   task automatic check_after(input string tag, input logic [7:0] es, input logic ec);
      @(negedge clk);
      chk({tag, "_done_width"}, 32'(done), 32'd0);
      chk({tag, "_sum_held"}, 32'(sum), 32'(es));
      chk({tag, "_cout_held"}, 32'(cout), 32'(ec));
   endtask

   initial begin
      bit extra_done;
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      sub   = 1'b0;
      #1;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_sum",  32'(sum),  32'd0);
      chk("reset_cout", 32'(cout), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      do_start(8'h05, 8'h03, 1'b0);
      wait_done("add_05_03", 8'h08, 1'b0, 8);
      check_after("add_05_03", 8'h08, 1'b0);

      do_start(8'hFF, 8'h01, 1'b0);
      wait_done("add_ff_01", 8'h00, 1'b1, 8);
      check_after("add_ff_01", 8'h00, 1'b1);

      do_start(8'hAA, 8'h55, 1'b0);
      wait_done("add_aa_55", 8'hFF, 1'b0, 8);
      check_after("add_aa_55", 8'hFF, 1'b0);

      // start pulse while busy must be ignored
      do_start(8'h01, 8'h01, 1'b0);
      repeat (2) @(negedge clk);
      a     = 8'h10;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("busy_start", 8'h02, 1'b0, 5);
      extra_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) extra_done = 1'b1;
      end
      chk("busy_start_single_done", 32'(extra_done), 32'd0);
      chk("busy_start_sum_held", 32'(sum), 32'h02);

      // reset mid-run aborts without done
      do_start(8'h0F, 8'h01, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_sum",  32'(sum),  32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_cout", 32'(cout), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      extra_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done || busy) extra_done = 1'b1;
      end
      chk("midrst_no_done", 32'(extra_done), 32'd0);
      do_start(8'h02, 8'h02, 1'b0);
      wait_done("add_02_02", 8'h04, 1'b0, 8);
      check_after("add_02_02", 8'h04, 1'b0);

      // back-to-back: start held through DONE; second operands presented during first run
      @(negedge clk);
      a     = 8'h80;
      b     = 8'h80;
      start = 1'b1;
      @(negedge clk);
      a     = 8'h30;
      b     = 8'h0C;
      wait_done("b2b_first", 8'h00, 1'b1, 8);
      @(negedge clk);
      start = 1'b0;
      chk("b2b_restart_busy", 32'(busy), 32'd1);
      chk("b2b_restart_done", 32'(done), 32'd0);
      wait_done("b2b_second", 8'h3C, 1'b0, 8);
      check_after("b2b_second", 8'h3C, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
      do_start(8'h05, 8'h07, 1'b1);
      wait_done("sub_05_07", 8'hFE, 1'b0, 8);
      check_after("sub_05_07", 8'hFE, 1'b0);

      do_start(8'h07, 8'h05, 1'b1);
      wait_done("sub_07_05", 8'h02, 1'b1, 8);
      check_after("sub_07_05", 8'h02, 1'b1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_serial_add_ctrl
